// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the debugger sample splitter and the UART transmitter.
interface uart_tx_serializer_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an 8N1 UART serialiser; baud timing from an integer clock divider.
module uart_tx_serializer #(
    parameter int unsigned CLK_HZ     = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_25mhz,
    input  logic                          rst_in,
    uart_tx_serializer_if.slave           bus,
    output logic                          uart_tx,
    output logic                          busy_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          overflow_out
);
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned CNT_W   = $clog2(DIV);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic               overflow_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;

    logic full_c, empty_c, push_c, pop_c, baud_last_c;

    assign full_c      = (count_q == COUNT_W'(FIFO_DEPTH));
    assign empty_c     = (count_q == COUNT_W'(0));
    assign push_c      = bus.valid_in && !full_c;
    assign baud_last_c = (baud_q == CNT_W'(DIV - 1));

    assign bus.ready_out  = !full_c;
    assign uart_tx        = tx_q;
    assign fifo_count_out = count_q;
    assign overflow_out   = overflow_q;
    assign busy_out       = (state_q != IDLE) || !empty_c;

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_25mhz) begin
        if (push_c) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_c && !pop_c) begin
                count_q <= count_q + COUNT_W'(1);
            end else if (!push_c && pop_c) begin
                count_q <= count_q - COUNT_W'(1);
            end
            if (bus.valid_in && full_c) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Line level is the registered view of the current state, so it trails the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last_c) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_last_c) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream stage of the UART debugger: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each as an 8N1 frame on the board UART TX pin.
- The debugger splits each 16-bit debug sample into bytes and pushes them here.
- Baud timing is derived from the 25 MHz system clock by an integer divider.

Parameters:
- CLK_HZ, 25000000, input clock frequency in Hz.
- BAUD, 115200, line rate; DIV = CLK_HZ / BAUD, integer truncating division (217 at defaults); DIV >= 2 required.
- FIFO_DEPTH, 16, byte entries; must be a power of 2 and >= 2.

Ports:
- clk_25mhz  input  1  system clock; all logic on posedge.
- rst_in  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in is valid this cycle.
- ready_out  output  1  FIFO can accept a byte; equals !full.
- uart_tx  output  1  serial line, registered, idles high.
- busy_out  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_out  output  1  sticky; set when valid_in is high while ready_out is low.

Behaviour:
- Reset (rst_in low, asynchronous) forces the following, and holds them while rst_in is low:
  - uart_tx = 1, ready_out = 1, busy_out = 0, fifo_count_out = 0, overflow_out = 0.
  - FIFO pointers = 0, state = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame; the line returns high immediately and FIFO contents are discarded.
- Push rules:
  - A byte is accepted on a rising edge where valid_in && ready_out.
  - With valid_in && !ready_out, the byte is dropped and overflow_out is set to 1; it is cleared only by reset.
- Pop rules:
  - A pop occurs only when the FIFO is non-empty and the FSM takes a byte: in IDLE, or on the last cycle of STOP.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- FSM state IDLE:
  - uart_tx = 1.
  - If the FIFO is non-empty: pop into the shift register, baud counter = 0, go to START.
- FSM state START:
  - uart_tx = 0 for exactly DIV cycles, then go to DATA with bit index = 0.
- FSM state DATA:
  - uart_tx = shift[0], LSB first.
  - Each bit is held DIV cycles, then shift right and increment bit index.
  - After bit 7 completes, go to STOP.
- FSM state STOP:
  - uart_tx = 1 for DIV cycles.
  - On the last cycle, if the FIFO is non-empty: pop and go directly to START, so there is no idle gap between frames.
  - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..DIV-1 within each bit and wraps to 0 at each bit boundary.
  - Width is $clog2(DIV).
- Frame timing:
  - A frame is exactly 10*DIV cycles of line time.
  - Back-to-back frames are 10*DIV cycles apart, start edge to start edge.
- Latency:
  - For a byte accepted at edge N into an empty FIFO with the FSM in IDLE, the pop occurs at edge N+1 and uart_tx is first low after edge N+2.
- busy_out is combinational: (state != IDLE) || (count != 0).

Test Plan:
- Run all scenarios with CLK_HZ=40, BAUD=10 (DIV=4).
- Reset then idle 20 cycles -> uart_tx=1, ready_out=1, busy_out=0, fifo_count_out=0, overflow_out=0 throughout.
- Push 0xA5 once into an idle block -> uart_tx low 2 cycles after the accept edge, then 4 cycles each of bits 1,0,1,0,0,1,0,1, then stop high 4 cycles; total 40 cycles; busy_out drops after the stop bit.
- Push 0x00 then 0xFF on consecutive cycles -> the second start bit begins exactly 40 cycles after the first; the line never idles between frames; fifo_count_out peaks at 1.
- Push 17 bytes 0x01..0x11 with valid_in held high every cycle -> one byte is popped at edge N+1, so ready_out falls once the count reaches 16; any byte offered while ready_out is low sets overflow_out=1 and is not transmitted; all accepted bytes appear on the line in order.
- Assert rst_in low mid-DATA of 0x3C with 3 bytes queued -> uart_tx goes high asynchronously, fifo_count_out=0, overflow_out=0, and nothing is transmitted after rst_in returns high.
- Push at the exact STOP-final cycle while the FIFO is empty -> the byte is accepted and sent after IDLE with the 2-cycle latency; fifo_count_out never exceeds 1.
